// File: rtl/mem_access_stage_if.sv
// MEM stage bus: execute-side operands in, write_back result out.
// Stall handshake travels alongside the data.
interface mem_access_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] b_ex;
  logic [1:0]        mode_ex;
  logic              valid_ex;
  logic              stall_ext;
  logic              dm_stall;
  logic [DATA_W-1:0] ans_dm;
  logic              valid_dm;

  modport master (
    output ans_ex, b_ex, mode_ex,
    output valid_ex, stall_ext,
    input  dm_stall, ans_dm, valid_dm
  );

  modport slave (
    input  ans_ex, b_ex, mode_ex,
    input  valid_ex, stall_ext,
    output dm_stall, ans_dm, valid_dm
  );
endinterface

// File: rtl/mem_access_stage.sv
// Data-memory pipeline stage: pass-through, store, and
// loads with MEM_LAT wait states that stall upstream.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_stage_if.slave bus
);
  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] M_PASS  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_STORE = 2'b10;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ans;
  logic              r_valid;
  logic              r_stall;

  logic [ADDR_W-1:0] w_addr;
  logic              w_idle_go;
  logic              w_wr;
  logic              w_unused;

  assign w_addr    = bus.ans_ex[ADDR_W-1:0];
  assign w_idle_go = reset && !bus.stall_ext
                   && r_state == S_IDLE
                   && bus.valid_ex;
  assign w_wr      = w_idle_go && bus.mode_ex == M_STORE;
  assign w_unused  = ^bus.ans_ex[DATA_W-1:ADDR_W];

  // Memory survives reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_addr] <= bus.b_ex;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_ans   <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.stall_ext) begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.valid_ex) begin
              case (bus.mode_ex)
                M_PASS: begin
                  r_ans   <= bus.ans_ex;
                  r_valid <= 1'b1;
                end
                M_LOAD: begin
                  if (MEM_LAT == 0) begin
                    r_ans   <= r_mem[w_addr];
                    r_valid <= 1'b1;
                  end else begin
                    r_addr  <= w_addr;
                    r_cnt   <= 2'(MEM_LAT - 1);
                    r_stall <= 1'b1;
                    r_state <= S_WAIT;
                  end
                end
                default: ;
              endcase
            end
          end
          S_WAIT: begin
            if (r_cnt != 2'd0) begin
              r_cnt <= r_cnt - 2'd1;
            end else begin
              r_ans   <= r_mem[r_addr];
              r_valid <= 1'b1;
              r_stall <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.ans_dm   = r_ans;
  assign bus.valid_dm = r_valid;
  assign bus.dm_stall = r_stall;
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory (MEM) pipeline stage of the 16-bit MIPS core.
- Sits between execute and write_back, and produces the ans_dm word that write_back registers into ans_wb.
- Holds a word-addressed data memory and performs loads, stores and ALU-result pass-through.
- Inserts wait states for loads and requests an upstream stall while the memory is busy.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, memory address width (2^ADDR_W words)
MEM_LAT, 1, extra wait cycles per load, legal 0..3

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
ans_ex  input  DATA_W  ALU result from execute; the memory address for loads and stores
b_ex  input  DATA_W  store data
mode_ex  input  2  00 pass-through, 01 load, 10 store, 11 nop
valid_ex  input  1  execute slot holds a real instruction
stall_ext  input  1  freeze from the stall-control unit
dm_stall  output  1  upstream must hold its outputs (load in progress)
ans_dm  output  DATA_W  result to write_back
valid_dm  output  1  ans_dm is a new, valid result this cycle

Behaviour:
- All state changes on posedge clk only. Reset is sampled at posedge: reset==0 forces:
  - ans_dm=0, valid_dm=0, dm_stall=0
  - FSM to IDLE, wait counter to 0
- Reset aborts any in-flight load and suppresses a store presented in the same cycle.
- Memory contents are not cleared by reset.
- Address is ans_ex[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo 2^ADDR_W.
- FSM states: IDLE and WAIT.
- IDLE, stall_ext=0: the stage accepts an instruction every edge:
  - Pass-through (00, valid_ex=1): ans_dm<=ans_ex, valid_dm<=1. Latency 1 cycle.
  - Store (10, valid_ex=1): mem[addr]<=b_ex at this edge; valid_dm<=0; ans_dm holds.
  - Nop (11), or valid_ex=0 with any mode: valid_dm<=0, ans_dm holds, no memory write.
  - Load (01, valid_ex=1), MEM_LAT=0: ans_dm<=mem[addr], valid_dm<=1. Latency 1 cycle.
  - Load (01, valid_ex=1), MEM_LAT>0:
    - At the accepting edge: latch addr, counter<=MEM_LAT-1, dm_stall<=1, valid_dm<=0, go to WAIT.
- WAIT, stall_ext=0:
  - Inputs are ignored.
  - counter>0: decrement.
  - counter==0: ans_dm<=mem[latched addr], valid_dm<=1, dm_stall<=0, go to IDLE.
- Load timing for MEM_LAT=N:
  - valid_dm is high N+1 edges after the load is accepted.
  - dm_stall is high for exactly N cycles.
  - The held next instruction is accepted on the edge after dm_stall falls.
- stall_ext=1 (highest priority below reset):
  - No input is accepted and no memory write occurs.
  - ans_dm holds and valid_dm<=0.
  - In WAIT the counter freezes and dm_stall stays 1.
  - A completion due on a stalled edge is deferred until the first edge with stall_ext=0.
- Read-after-write: a store followed by a load to the same address returns the newly stored data. The store writes on the earlier edge.
- Back-to-back store then load, or load then store: each is accepted on its own edge with no extra penalty beyond MEM_LAT.
- valid_dm is a one-cycle pulse per completed pass-through or load.

Test Plan:
1. Reset and pass-through, MEM_LAT=1:
   - Stimulus: reset=0 for 2 cycles, then mode_ex=00, ans_ex=2, then ans_ex=3.
   - Required: ans_dm=0 and valid_dm=0 during reset; ans_dm=2 one edge after release, then 3, valid_dm=1 on both.
2. Store then load, MEM_LAT=1:
   - Stimulus: store b_ex=0xBEEF to addr 0x05, then load addr 0x05.
   - Required: dm_stall=1 for exactly 1 cycle; ans_dm=0xBEEF with valid_dm=1 two edges after the load is accepted.
3. Address wrap, MEM_LAT=0:
   - Stimulus: store 0x1234 using ans_ex=0x0107, then load ans_ex=0x0007.
   - Required: ans_dm=0x1234 one edge after the load is accepted.
4. External stall during a load, MEM_LAT=2:
   - Stimulus: raise stall_ext for 3 cycles starting in the first WAIT cycle.
   - Required: completion slips by 3 cycles; no memory write during the stall; ans_dm unchanged while stalled.
5. Reset mid-load, MEM_LAT=3:
   - Stimulus: reset=0 during WAIT.
   - Required: dm_stall=0, valid_dm=0 and ans_dm=0 after the reset edge; a later load of the same address returns the value that was stored before reset.
6. Nop and invalid slots:
   - Stimulus: mode_ex=11, then valid_ex=0 with mode_ex=10 and b_ex=0xFFFF to addr 0x05.
   - Required: valid_dm=0 for both; mem[0x05] unchanged (a following load returns 0xBEEF).
